wb_reg_responder: RTL and testbench

WB_REG_RESPONDER -- requirements
Module: wb_reg_responder

---
 rtl/wb_reg_responder.sv | 156 +++++++++++++++
 tb/tb_wb_reg_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_responder.sv
// Wishbone slave exposing NREG word registers with configurable wait states.
// Every request gets exactly one registered ack/err pulse followed by one idle gap cycle.
module wb_reg_responder #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int BW   = 4,
  parameter int NREG = 8,
  parameter int WAIT = 1
) (
  input  logic                 wbs_clk_i,
  input  logic                 wbs_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic [AW-1:0]        wbs_adr_i,
  input  logic                 wbs_we_i,
  input  logic [DW-1:0]        wbs_dat_i,
  input  logic [BW-1:0]        wbs_sel_i,
  output logic [DW-1:0]        wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic [NREG*DW-1:0]   reg_o
);

  localparam int IW = $clog2(NREG);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [AW-1:0] NREG_A = AW'(NREG);

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_s;
  logic [AW-1:0] adr_r;
  logic          we_r;
  logic [DW-1:0] dat_r;
  logic [BW-1:0] sel_r;
  logic          ack_r;
  logic          err_r;
  logic [DW-1:0] rdata_r;
  logic [DW-1:0] regs_r [NREG];

  logic          req_s;
  logic          go_resp_s;
  logic [AW-1:0] cur_adr_s;
  logic          cur_we_s;
  logic          cur_valid_s;
  logic [IW-1:0] cur_idx_s;
  logic [IW-1:0] wr_idx_s;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < NREG_A);
  endfunction

  assign req_s = wbs_cyc_i & wbs_stb_i;

  // With zero wait states the response is decided from the live bus in IDLE.
  assign cur_adr_s   = (state_r == S_IDLE) ? wbs_adr_i : adr_r;
  assign cur_we_s    = (state_r == S_IDLE) ? wbs_we_i  : we_r;
  assign cur_valid_s = addr_ok(cur_adr_s);
  assign cur_idx_s   = cur_adr_s[IW+1:2];
  assign wr_idx_s    = adr_r[IW+1:2];

  // Next-state and wait-counter logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    go_resp_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          if (WAIT > 0) begin
            state_s = S_WAIT;
            cnt_s   = WAIT_LOAD;
          end else begin
            state_s   = S_RESP;
            go_resp_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!req_s) begin
          state_s = S_IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_s   = S_RESP;
          go_resp_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_RESP:  state_s = S_GAP;
      S_GAP:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state, latched request and registered response outputs.
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      adr_r   <= '0;
      we_r    <= 1'b0;
      dat_r   <= '0;
      sel_r   <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (state_r == S_IDLE && req_s) begin
        adr_r <= wbs_adr_i;
        we_r  <= wbs_we_i;
        dat_r <= wbs_dat_i;
        sel_r <= wbs_sel_i;
      end
      ack_r   <= go_resp_s & cur_valid_s;
      err_r   <= go_resp_s & ~cur_valid_s;
      rdata_r <= (go_resp_s && cur_valid_s && !cur_we_s) ? regs_r[cur_idx_s] : '0;
    end
  end

  // Byte-masked register write on the edge that closes the RESP cycle.
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      for (int k = 0; k < NREG; k++) begin
        regs_r[k] <= '0;
      end
    end else if (state_r == S_RESP && ack_r && we_r) begin
      for (int i = 0; i < BW; i++) begin
        if (sel_r[i]) begin
          regs_r[wr_idx_s][8*i +: 8] <= dat_r[8*i +: 8];
        end
      end
    end
  end

  // Flatten the register file onto reg_o.
  always_comb begin
    reg_o = '0;
    for (int k = 0; k < NREG; k++) begin
      reg_o[k*DW +: DW] = regs_r[k];
    end
  end

  assign wbs_dat_o = rdata_r;
  assign wbs_ack_o = ack_r;
  assign wbs_err_o = err_r;

endmodule

// File: tb/tb_wb_reg_responder.sv
// Scoreboard bench for wb_reg_responder: one instance with WAIT=1, one with WAIT=3.
module tb_wb_reg_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NREG = 8;

  typedef struct {
    logic          is_err;
    logic          is_read;
    logic [DW-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst  [2];
  logic                cyc  [2];
  logic                stb  [2];
  logic [AW-1:0]       adr  [2];
  logic                we   [2];
  logic [DW-1:0]       wdat [2];
  logic [BW-1:0]       sel  [2];
  logic [DW-1:0]       rdat [2];
  logic                ack  [2];
  logic                err  [2];
  logic [NREG*DW-1:0]  rego [2];

  logic [DW-1:0] model [2][NREG];
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  wb_reg_responder #(.AW(AW), .DW(DW), .BW(BW), .NREG(NREG), .WAIT(1)) dut_w1 (
    .wbs_clk_i(clk), .wbs_rst_i(rst[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_adr_i(adr[0]), .wbs_we_i(we[0]), .wbs_dat_i(wdat[0]), .wbs_sel_i(sel[0]),
    .wbs_dat_o(rdat[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]), .reg_o(rego[0])
  );

  wb_reg_responder #(.AW(AW), .DW(DW), .BW(BW), .NREG(NREG), .WAIT(3)) dut_w3 (
    .wbs_clk_i(clk), .wbs_rst_i(rst[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_adr_i(adr[1]), .wbs_we_i(we[1]), .wbs_dat_i(wdat[1]), .wbs_sel_i(sel[1]),
    .wbs_dat_o(rdat[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]), .reg_o(rego[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic addr_valid(input logic [AW-1:0] a);
    logic [AW-1:0] lim;
    lim = AW'(NREG);
    return (a[1:0] == 2'b00) && ((a >> 2) < lim);
  endfunction

  task automatic drive(input int d, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] dv, input logic [BW-1:0] s);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dv; sel[d] = s;
  endtask

  task automatic idle_bus(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; wdat[d] = '0; sel[d] = '0;
  endtask

  // Expected response computed at issue time; model holds post-completion state.
  task automatic push_exp(input int d, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] dv, input logic [BW-1:0] s);
    exp_t e;
    int idx;
    e.is_err = !addr_valid(a);
    e.is_read = !w;
    e.dat = '0;
    if (!e.is_err) begin
      idx = int'(a[4:2]);
      if (w) begin
        for (int i = 0; i < BW; i++)
          if (s[i]) model[d][idx][8*i +: 8] = dv[8*i +: 8];
      end else begin
        e.dat = model[d][idx];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic check_resp(input int d, input string name);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: response with empty scoreboard ack=%b err=%b", name, ack[d], err[d]);
    end else begin
      e = exp_q.pop_front();
      if (ack[d] !== !e.is_err || err[d] !== e.is_err) begin
        fails++;
        $display("FAIL %s kind: got ack=%b err=%b expected ack=%b err=%b",
                 name, ack[d], err[d], !e.is_err, e.is_err);
      end
      if (e.is_read || e.is_err) begin
        tests++;
        if (rdat[d] !== e.dat) begin
          fails++;
          $display("FAIL %s data: got %h expected %h", name, rdat[d], e.dat);
        end
      end
    end
  endtask

  task automatic check_regs(input int d, input string name);
    logic [NREG*DW-1:0] ev;
    for (int k = 0; k < NREG; k++) ev[k*DW +: DW] = model[d][k];
    tests++;
    if (rego[d] !== ev) begin
      fails++;
      $display("FAIL %s reg_o: got %h expected %h", name, rego[d], ev);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge in IDLE.
  task automatic do_req(input int d, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] dv, input logic [BW-1:0] s, input string name);
    int n;
    logic seen;
    drive(d, w, a, dv, s);
    push_exp(d, w, a, dv, s);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[d] === 1'b1 || err[d] === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: no response after %0d cycles, expected at %0d", name, n, wait_of(d) + 1);
      void'(exp_q.pop_front());
      idle_bus(d);
      @(negedge clk);
    end else begin
      if (n != wait_of(d) + 1) begin
        fails++;
        $display("FAIL %s latency: got %0d expected %0d", name, n, wait_of(d) + 1);
      end
      check_resp(d, name);
      idle_bus(d);
      @(negedge clk);
      tests++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdat[d] !== '0) begin
        fails++;
        $display("FAIL %s gap: got ack=%b err=%b dat=%h expected 0 0 0", name, ack[d], err[d], rdat[d]);
      end
      check_regs(d, name);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      idle_bus(d);
      for (int k = 0; k < NREG; k++) model[d][k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdat[d] !== '0) begin
        fails++;
        $display("FAIL reset_out%0d: got ack=%b err=%b dat=%h expected 0 0 0", d, ack[d], err[d], rdat[d]);
      end
      check_regs(d, "reset_regs");
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    do_req(0, 1'b0, 32'h0000_0000, 32'h0, 4'hF, "first_after_reset");
  endtask

  task automatic test_write_basic();
    do_req(0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, "wr_basic");
    tests++;
    if (rego[0][2*DW +: DW] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL wr_basic reg2: got %h expected %h", rego[0][2*DW +: DW], 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_byte_sel();
    do_req(0, 1'b1, 32'h0000_0008, 32'h1122_3344, 4'h5, "wr_sel5");
    tests++;
    if (rego[0][2*DW +: DW] !== 32'hDE22_BE44) begin
      fails++;
      $display("FAIL wr_sel5 reg2: got %h expected %h", rego[0][2*DW +: DW], 32'hDE22_BE44);
    end
    do_req(0, 1'b0, 32'h0000_0008, 32'h0, 4'h0, "rd_reg2");
    do_req(0, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, "wr_sel0");
    do_req(0, 1'b1, 32'h0000_001C, 32'h7654_3210, 4'hA, "wr_last");
    do_req(0, 1'b0, 32'h0000_001C, 32'h0, 4'h0, "rd_last");
  endtask

  task automatic test_invalid();
    do_req(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, "rd_oob");
    do_req(0, 1'b0, 32'h0000_0006, 32'h0, 4'hF, "rd_misaligned");
    do_req(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, "wr_oob");
    do_req(0, 1'b1, 32'h0000_000A, 32'hFFFF_FFFF, 4'hF, "wr_misaligned");
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    drive(0, 1'b1, 32'h0000_000C, 32'h0BAD_F00D, 4'hF);
    push_exp(0, 1'b1, 32'h0000_000C, 32'h0BAD_F00D, 4'hF);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      exp_ack = (n == 2 || n == 6 || n == 10);
      tests++;
      if (ack[0] !== exp_ack || err[0] !== 1'b0) begin
        fails++;
        $display("FAIL b2b cycle %0d: got ack=%b err=%b expected ack=%b err=0", n, ack[0], err[0], exp_ack);
      end
      if (ack[0] === 1'b1) check_resp(0, "b2b");
      if (n == 3) begin
        drive(0, 1'b0, 32'h0000_000C, 32'h0, 4'h0);
        push_exp(0, 1'b0, 32'h0000_000C, 32'h0, 4'h0);
      end else if (n == 7) begin
        drive(0, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
        push_exp(0, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
      end else if (n == 11) begin
        idle_bus(0);
      end
    end
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b drained: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    check_regs(0, "b2b");
  endtask

  task automatic test_abort();
    drive(1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    @(negedge clk);
    cyc[1] = 1'b0;
    for (int n = 3; n <= 9; n++) begin
      @(negedge clk);
      if (n == 3) idle_bus(1);
      tests++;
      if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
        fails++;
        $display("FAIL abort cycle %0d: got ack=%b err=%b expected 0 0", n, ack[1], err[1]);
      end
    end
    check_regs(1, "abort");
    do_req(1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, "after_abort_wr");
    do_req(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, "after_abort_rd");
  endtask

  task automatic test_reset_mid();
    do_req(1, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 4'hF, "pre_reset_wr");
    tests++;
    if (rego[1][DW +: DW] !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL pre_reset reg1: got %h expected %h", rego[1][DW +: DW], 32'hA5A5_A5A5);
    end
    drive(1, 1'b1, 32'h0000_0004, 32'h5A5A_5A5A, 4'hF);
    @(negedge clk);
    rst[1] = 1'b1;
    for (int k = 0; k < NREG; k++) model[1][k] = '0;
    #1;
    tests++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0 || rdat[1] !== '0) begin
      fails++;
      $display("FAIL mid_reset out: got ack=%b err=%b dat=%h expected 0 0 0", ack[1], err[1], rdat[1]);
    end
    check_regs(1, "mid_reset");
    @(negedge clk);
    idle_bus(1);
    @(negedge clk);
    rst[1] = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      tests++;
      if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
        fails++;
        $display("FAIL post_reset cycle %0d: got ack=%b err=%b expected 0 0", n, ack[1], err[1]);
      end
    end
    check_regs(1, "post_reset");
    do_req(1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, "post_reset_rd");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_byte_sel();
    test_invalid();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
